// File: rtl/temp_pkg.sv
// Shared definitions for the temperature readout path (SPI stage, converter, display mux).
package temp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ADD  = 2'd2,
        BCD  = 2'd3
    } state_t;

    localparam int CF_MUL     = 9;
    localparam int CF_DIV     = 5;
    localparam int F_OFFSET   = 32;
    localparam int DIV_CYCLES = 12;
    localparam int BCD_CYCLES = 10;

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/temp_bcd_seq_if.sv
// Handshake and digit bus between the LM70 latch stage, the converter and the display mux.
interface temp_bcd_seq_if #(
    parameter int IN_W = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] temp_c;
    logic            sel_f;
    logic            out_valid;
    logic [3:0]      bcd_hund;
    logic [3:0]      bcd_tens;
    logic [3:0]      bcd_ones;
    logic            unit_f;

    modport master (
        output in_valid, temp_c, sel_f,
        input  in_ready, out_valid, bcd_hund, bcd_tens, bcd_ones, unit_f
    );

    modport slave (
        input  in_valid, temp_c, sel_f,
        output in_ready, out_valid, bcd_hund, bcd_tens, bcd_ones, unit_f
    );
endinterface

// File: rtl/bcd_dd_seq.sv
// Iterative shift-add-3 binary to 3-digit BCD converter, one shift per clock.
module bcd_dd_seq
    import temp_pkg::*;
#(
    parameter int VAL_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    output logic             done,
    output logic [3:0]       hund,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);
    logic [11:0]        bcd;
    logic [VAL_W-1:0]   bin;
    logic [3:0]         cnt;
    logic               active;
    logic [11:0]        bcd_nxt;
    logic [VAL_W-1:0]   bin_nxt;
    logic [VAL_W+11:0]  work;

    always_comb begin
        work    = {dd_adj(bcd[11:8]), dd_adj(bcd[7:4]), dd_adj(bcd[3:0]), bin};
        work    = work << 1;
        bcd_nxt = work[VAL_W+11:VAL_W];
        bin_nxt = work[VAL_W-1:0];
    end

    assign done = active && (cnt == 4'(BCD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd    <= '0;
            bin    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            hund   <= '0;
            tens   <= '0;
            ones   <= '0;
        end else if (load) begin
            bcd    <= '0;
            bin    <= value;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            bcd <= bcd_nxt;
            bin <= bin_nxt;
            cnt <= cnt + 4'd1;
            // Digits only move on the final shift so the display never sees partials.
            if (done) begin
                active <= 1'b0;
                hund   <= bcd_nxt[11:8];
                tens   <= bcd_nxt[7:4];
                ones   <= bcd_nxt[3:0];
            end
        end
    end
endmodule

// File: rtl/temp_bcd_seq.sv
// Exact C->F conversion (floor(9C/5)+32) followed by sequential BCD digit generation.
//   state | meaning
//   IDLE  | ready; accept captures temp_c/sel_f
//   DIV   | restoring divide of 9C by 5, one quotient bit per edge
//   ADD   | add the 32 F offset, start BCD conversion
//   BCD   | double-dabble running; digits written on its last edge
module temp_bcd_seq
    import temp_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int VAL_W  = 10,
    parameter int PROD_W = 12
) (
    input  logic          clk,
    input  logic          rst,
    temp_bcd_seq_if.slave bus
);
    state_t             state, state_nxt;
    logic [PROD_W-1:0]  div_q;
    logic [2:0]         rem;
    logic [3:0]         div_cnt;
    logic [3:0]         trial;
    logic               q_bit;
    logic               sel_q;
    logic               accept;
    logic               load;
    logic [VAL_W-1:0]   load_val;
    logic               dd_done;

    assign accept = bus.in_valid && (state == IDLE);
    assign trial  = {rem, div_q[PROD_W-1]};
    assign q_bit  = (trial >= 4'(CF_DIV));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = bus.sel_f ? DIV : BCD;
            DIV:  if (div_cnt == 4'(DIV_CYCLES - 1)) state_nxt = ADD;
            ADD:  state_nxt = BCD;
            BCD:  if (dd_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == IDLE);
        load         = 1'b0;
        load_val     = '0;
        if (accept && !bus.sel_f) begin
            load     = 1'b1;
            load_val = VAL_W'(bus.temp_c);
        end else if (state == ADD) begin
            load     = 1'b1;
            load_val = VAL_W'(div_q) + VAL_W'(F_OFFSET);
        end
    end

    // div_q holds the dividend and shifts the quotient in from the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            rem           <= '0;
            div_cnt       <= '0;
            sel_q         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.unit_f    <= 1'b0;
        end else begin
            bus.out_valid <= dd_done;
            if (dd_done) bus.unit_f <= sel_q;
            if (accept) begin
                sel_q   <= bus.sel_f;
                div_q   <= (PROD_W'(bus.temp_c) << 3) + PROD_W'(bus.temp_c);
                rem     <= '0;
                div_cnt <= '0;
            end else if (state == DIV) begin
                div_q   <= {div_q[PROD_W-2:0], q_bit};
                rem     <= q_bit ? 3'(trial - 4'(CF_DIV)) : trial[2:0];
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end

    bcd_dd_seq #(.VAL_W(VAL_W)) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (load_val),
        .done  (dd_done),
        .hund  (bus.bcd_hund),
        .tens  (bus.bcd_tens),
        .ones  (bus.bcd_ones)
    );
endmodule

// File: tb/tb_temp_bcd_seq.sv
// Directed and exhaustive checks of the C/F BCD converter against hand values and floor(9C/5)+32.
module tb_temp_bcd_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    temp_bcd_seq_if #(.IN_W(8)) bus ();

    temp_bcd_seq #(.IN_W(8), .VAL_W(10), .PROD_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int last_val = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int digits_now();
        return int'(bus.bcd_hund) * 100 + int'(bus.bcd_tens) * 10 + int'(bus.bcd_ones);
    endfunction

    task automatic convert(input int c, input bit f, input int exp_val, input string tag);
        int lat;
        bit seen, busy_ok, hold_ok;
        lat = 0; seen = 0; busy_ok = 1; hold_ok = 1;
        @(negedge clk);
        bus.temp_c   = 8'(c);
        bus.sel_f    = f;
        bus.in_valid = 1'b1;
        chk({tag, "_ready_before"}, int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.temp_c   = 8'(c ^ 8'h5A);
        bus.sel_f    = ~f;
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (i > 1) begin
                @(posedge clk); #1;
            end
            if (i > 1 && bus.out_valid) begin
                seen = 1;
                lat  = i - 1;
            end else begin
                if (bus.in_ready) busy_ok = 0;
                if (digits_now() != last_val) hold_ok = 0;
            end
        end
        chk({tag, "_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, lat, f ? 23 : 10);
        chk({tag, "_digits"}, digits_now(), exp_val);
        chk({tag, "_unit"}, int'(bus.unit_f), int'(f));
        chk({tag, "_busy"}, int'(busy_ok), 1);
        chk({tag, "_hold"}, int'(hold_ok), 1);
        chk({tag, "_ready_after"}, int'(bus.in_ready), 1);
        @(posedge clk); #1;
        chk({tag, "_pulse_once"}, int'(bus.out_valid), 0);
        chk({tag, "_digits_keep"}, digits_now(), exp_val);
        last_val = exp_val;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, p1, v1, p2, v2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.temp_c   = '0;
        bus.sel_f    = 1'b0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_digits", digits_now(), 0);
        chk("rst_unit", int'(bus.unit_f), 0);
        chk("rst_ready", int'(bus.in_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        convert(25,  1'b0, 25,  "c25");
        convert(25,  1'b1, 77,  "f25");
        convert(37,  1'b1, 98,  "f37_floor");
        convert(0,   1'b1, 32,  "f0");
        convert(100, 1'b1, 212, "f100");
        convert(255, 1'b1, 491, "f255");
        convert(255, 1'b0, 255, "c255");
        convert(0,   1'b0, 0,   "c0");
        convert(255, 1'b1, 491, "f255_again");

        // Reset in the middle of a divide must clear everything immediately.
        @(negedge clk);
        bus.temp_c = 8'd100; bus.sel_f = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_digits", digits_now(), 0);
        chk("midrst_unit", int'(bus.unit_f), 0);
        chk("midrst_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        last_val = 0;
        convert(25, 1'b0, 25, "post_rst_c25");

        // in_valid held high: only values present at accept edges are converted.
        npulse = 0; p1 = -1; v1 = -1; p2 = -1; v2 = -1;
        @(negedge clk);
        bus.sel_f    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 26; i++) begin
            bus.temp_c = 8'(100 + i);
            @(posedge clk); #1;
            if (bus.out_valid) begin
                npulse++;
                if (npulse == 1) begin p1 = i; v1 = digits_now(); end
                else if (npulse == 2) begin p2 = i; v2 = digits_now(); end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("stream_pulses", npulse, 2);
        chk("stream_p1_edge", p1, 10);
        chk("stream_p1_val", v1, 100);
        chk("stream_p2_edge", p2, 21);
        chk("stream_p2_val", v2, 111);
        repeat (15) @(posedge clk);
        #1;
        chk("stream_p3_val", digits_now(), 122);
        chk("stream_idle", int'(bus.in_ready), 1);
        last_val = 122;

        for (int c = 0; c < 256; c++) begin
            for (int s = 0; s < 2; s++) begin
                convert(c, s[0], (s != 0) ? (9 * c) / 5 + 32 : c,
                        $sformatf("sweep_c%0d_f%0d", c, s));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
